// File: rtl/keyexp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : keyexp_sequencer
// Description : Drives a shared chaotic-map unit to expand two key vectors
//               (M and N) of DEPTH entries each into a key buffer.
//               Optional cancel input enabled by defining KEYEXP_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module keyexp_sequencer #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] seed_m,
    input  logic [WIDTH-1:0] seed_n,
    input  logic [WIDTH-1:0] r1,
    input  logic [WIDTH-1:0] r2,
    output logic             map_req,
    output logic [WIDTH-1:0] map_x0,
    output logic [WIDTH-1:0] map_rfs,
    output logic [WIDTH-1:0] map_rs,
    input  logic             map_ack,
    input  logic [WIDTH-1:0] map_x_next,
    output logic             wr_en,
    output logic             wr_sel,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             busy,
`ifdef KEYEXP_ABORT_EN
    output logic             done,
    input  logic             abort
`else
    output logic             done
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEED_M = 3'd1,
        S_SEED_N = 3'd2,
        S_CALC_M = 3'd3,
        S_CALC_N = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    state_e           state_q;
    logic [AW-1:0]    idx_q;
    logic [WIDTH-1:0] seed_m_q;
    logic [WIDTH-1:0] seed_n_q;
    logic [WIDTH-1:0] r1_q;
    logic [WIDTH-1:0] r2_q;
    logic [WIDTH-1:0] last_m_q;
    logic [WIDTH-1:0] last_n_q;
    logic             w_abort;

`ifdef KEYEXP_ABORT_EN
    assign w_abort = abort && (state_q != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            seed_m_q <= '0;
            seed_n_q <= '0;
            r1_q     <= '0;
            r2_q     <= '0;
            last_m_q <= '0;
            last_n_q <= '0;
        end else if (w_abort) begin
            // Cancel wins over a coincident map_ack: no state besides the FSM moves.
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        seed_m_q <= seed_m;
                        seed_n_q <= seed_n;
                        r1_q     <= r1;
                        r2_q     <= r2;
                        state_q  <= S_SEED_M;
                    end
                end
                S_SEED_M: begin
                    last_m_q <= seed_m_q;
                    state_q  <= S_SEED_N;
                end
                S_SEED_N: begin
                    last_n_q <= seed_n_q;
                    idx_q    <= AW'(1);
                    state_q  <= S_CALC_M;
                end
                S_CALC_M: begin
                    if (map_ack) begin
                        last_m_q <= map_x_next;
                        state_q  <= S_CALC_N;
                    end
                end
                S_CALC_N: begin
                    if (map_ack) begin
                        last_n_q <= map_x_next;
                        if (idx_q == AW'(DEPTH - 1)) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q + AW'(1);
                            state_q <= S_CALC_M;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs decode from the registered state; the map result is forwarded
    // to the buffer in its ack cycle so zero-wait runs write every cycle.
    always_comb begin
        map_req = 1'b0;
        map_x0  = '0;
        map_rfs = '0;
        map_rs  = '0;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE) && !w_abort;
        case (state_q)
            S_SEED_M: begin
                if (!w_abort) begin
                    wr_en   = 1'b1;
                    wr_data = seed_m_q;
                end
            end
            S_SEED_N: begin
                if (!w_abort) begin
                    wr_en   = 1'b1;
                    wr_sel  = 1'b1;
                    wr_data = seed_n_q;
                end
            end
            S_CALC_M: begin
                map_req = 1'b1;
                map_x0  = last_m_q;
                map_rfs = r1_q;
                map_rs  = r2_q;
                if (map_ack && !w_abort) begin
                    wr_en   = 1'b1;
                    wr_addr = idx_q;
                    wr_data = map_x_next;
                end
            end
            S_CALC_N: begin
                map_req = 1'b1;
                map_x0  = last_n_q;
                map_rfs = r2_q;
                map_rs  = r1_q;
                if (map_ack && !w_abort) begin
                    wr_en   = 1'b1;
                    wr_sel  = 1'b1;
                    wr_addr = idx_q;
                    wr_data = map_x_next;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_keyexp_sequencer.sv
`default_nettype none
// Testbench for keyexp_sequencer: table of runs against a vector-level model,
// plus hand-written reset and abort sequences.
module tb_keyexp_sequencer;
    localparam int W  = 32;
    localparam int D  = 256;
    localparam int AW = 8;

    typedef struct {
        logic         sel;
        logic [AW-1:0] addr;
        logic [W-1:0] data;
        int           cyc;
    } wr_t;

    typedef struct {
        logic [W-1:0] sm;
        logic [W-1:0] sn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           wait_n;
        bit           rnd;
        int           fmode;
        bit           glitch;
        int           done_off;
    } run_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  seed_m = '0, seed_n = '0, r1 = '0, r2 = '0;
    logic          map_req, map_ack;
    logic [W-1:0]  map_x0, map_rfs, map_rs, map_x_next;
    logic          wr_en, wr_sel, busy, done;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
`ifdef KEYEXP_ABORT_EN
    logic          abort = 1'b0;
`endif

    int checks = 0, failures = 0;
    int cyc = 0;
    int cfg_wait = 0, fmode = 0;
    bit cfg_rnd = 1'b0;
    int wait_n = 0, wcnt = 0, wait_tot = 0;
    logic [W-1:0] run_r1 = '0, run_r2 = '0;
    wr_t wq[$];
    int wbase = 0, done_cnt = 0, done_cyc = 0, route_err = 0;
    int g_db = 0, g_rb = 0, g_wt = 0, g_t = 0;
    run_t rows[6];

    keyexp_sequencer #(.WIDTH(W), .DEPTH(D)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed_m    (seed_m),
        .seed_n    (seed_n),
        .r1        (r1),
        .r2        (r2),
        .map_req   (map_req),
        .map_x0    (map_x0),
        .map_rfs   (map_rfs),
        .map_rs    (map_rs),
        .map_ack   (map_ack),
        .map_x_next(map_x_next),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
`ifdef KEYEXP_ABORT_EN
        .done      (done),
        .abort     (abort)
`else
        .done      (done)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] fmap(input int mode, input logic [W-1:0] x,
                                          input logic [W-1:0] p, input logic [W-1:0] q);
        if (mode == 0) return x + 32'd1;
        return x * 32'd5 + p - q;
    endfunction

    // Map unit model: a pure function of its operands, acking after wait_n cycles.
    assign map_x_next = fmap(fmode, map_x0, map_rfs, map_rs);
    assign map_ack    = map_req && (wcnt >= wait_n);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (map_req && map_ack) begin
            wcnt   <= 0;
            wait_n <= cfg_rnd ? int'($urandom_range(0, 3)) : cfg_wait;
        end else if (map_req) begin
            wcnt     <= wcnt + 1;
            wait_tot <= wait_tot + 1;
        end else begin
            wcnt   <= 0;
            wait_n <= cfg_rnd ? int'($urandom_range(0, 3)) : cfg_wait;
        end
    end

    // Each request must feed back the previous value of the same vector.
    always @(negedge clk) begin
        int k;
        if (map_req) begin
            k = wq.size() - wbase;
            if (k < 2) route_err++;
            else if (k % 2 == 0) begin
                if (map_x0 !== wq[wbase + k - 2].data || map_rfs !== run_r1 || map_rs !== run_r2)
                    route_err++;
            end else begin
                if (map_x0 !== wq[wbase + k - 2].data || map_rfs !== run_r2 || map_rs !== run_r1)
                    route_err++;
            end
        end
        if (wr_en) wq.push_back('{wr_sel, wr_addr, wr_data, cyc + 1});
        if (done) begin
            done_cnt++;
            done_cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctrl"}, int'({map_req, wr_en, busy, done, wr_sel}), 0);
        chk({tag, "_addr"}, int'(wr_addr), 0);
        chk({tag, "_data"}, int'(wr_data | map_x0 | map_rfs | map_rs), 0);
    endtask

    task automatic kick(input run_t r);
        seed_m = r.sm; seed_n = r.sn; r1 = r.a; r2 = r.b;
        run_r1 = r.a; run_r2 = r.b;
        cfg_wait = r.wait_n; cfg_rnd = r.rnd; fmode = r.fmode;
        wbase = wq.size(); g_db = done_cnt; g_rb = route_err; g_wt = wait_tot;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        g_t = cyc;
        // Inputs change after acceptance; the run must keep its latched copies.
        seed_m = $urandom; seed_n = $urandom; r1 = $urandom; r2 = $urandom;
    endtask

    task automatic run_one(input run_t r);
        logic [W-1:0]  em[D];
        logic [W-1:0]  en[D];
        int            n, bad, first_k, ecyc, exp_off;
        logic          esel;
        logic [AW-1:0] eaddr;
        logic [W-1:0]  ed;
        string         msg;
        wr_t           e;
        kick(r);
        for (int c = 0; c < 2 * D * 5 + 50; c++) begin
            start = (r.glitch && (cyc == g_t + 4 || cyc == g_t + 99)) ? 1'b1 : 1'b0;
            if (done_cnt > g_db && cyc > done_cyc + 2) break;
            @(posedge clk); #1;
        end
        start = 1'b0;

        em[0] = r.sm;
        en[0] = r.sn;
        for (int i = 1; i < D; i++) begin
            em[i] = fmap(r.fmode, em[i-1], r.a, r.b);
            en[i] = fmap(r.fmode, en[i-1], r.b, r.a);
        end
        n = wq.size() - wbase;
        chk("write_count", n, 2 * D);
        bad = 0; first_k = -1; msg = "";
        for (int k = 0; k < 2 * D && k < n; k++) begin
            e     = wq[wbase + k];
            esel  = (k % 2 == 1);
            eaddr = AW'(k / 2);
            ed    = esel ? en[k/2] : em[k/2];
            ecyc  = g_t + 1 + k + ((k >= 2) ? (k - 1) * r.wait_n : 0);
            if (e.sel !== esel || e.addr !== eaddr || e.data !== ed || (!r.rnd && e.cyc != ecyc)) begin
                bad++;
                if (first_k < 0) begin
                    first_k = k;
                    msg = $sformatf("k=%0d got sel=%0d addr=%0d data=%0d cyc=%0d expected sel=%0d addr=%0d data=%0d cyc=%0d",
                                    k, e.sel, e.addr, e.data, e.cyc - g_t, esel, eaddr, ed, ecyc - g_t);
                end
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL write_seq: %0d bad entries, first %s", bad, msg);
        end
        exp_off = (r.done_off >= 0) ? r.done_off : 2 * D + 1 + (wait_tot - g_wt);
        chk("done_count", done_cnt - g_db, 1);
        chk("done_cycle", done_cyc - g_t, exp_off);
        chk("routing_errors", route_err - g_rb, 0);
        chk("busy_after", int'(busy), 0);
    endtask

    initial begin
        rows[0] = '{32'd5, 32'd9, 32'd7, 32'd11, 0, 1'b0, 0, 1'b0, 513};
        rows[1] = '{$urandom, $urandom, $urandom, $urandom, 1, 1'b0, 1, 1'b0, 1023};
        rows[2] = '{$urandom, $urandom, $urandom, $urandom, 3, 1'b0, 1, 1'b0, 2043};
        rows[3] = '{$urandom, $urandom, $urandom, $urandom, 0, 1'b1, 1, 1'b0, -1};
        rows[4] = '{$urandom, $urandom, $urandom, $urandom, 0, 1'b0, 1, 1'b1, 513};
        rows[5] = '{$urandom, $urandom, $urandom, $urandom, 2, 1'b0, 1, 1'b0, 1533};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", int'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            run_one(rows[i]);
            if (i == 0) begin
                chk("M255", (wq.size() > wbase + 511) ? int'(wq[wbase + 510].data) : -1, 260);
                chk("N255", (wq.size() > wbase + 511) ? int'(wq[wbase + 511].data) : -1, 264);
            end
        end

        // Reset while N[40] is being computed.
        kick(rows[1]);
        for (int c = 0; c < 1000; c++) begin
            if (wq.size() - wbase == 81 && map_req) break;
            @(posedge clk); #1;
        end
        chk("rst_at_idx40", wq.size() - wbase, 81);
        rst_n = 1'b0;
        #1;
        chk_quiet("midrun_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_idle_busy", int'(busy), 0);
        chk("rst_no_done", done_cnt - g_db, 0);
        run_one(rows[5]);

`ifdef KEYEXP_ABORT_EN
        kick(rows[3]);
        cfg_rnd = 1'b0;
        cfg_wait = 0;
        for (int c = 0; c < 1000; c++) begin
            if (wq.size() - wbase == 20 && map_req && map_ack) break;
            @(posedge clk); #1;
        end
        chk("abort_at_idx10", wq.size() - wbase, 20);
        abort = 1'b1;
        #1;
        chk("abort_wr_en", int'(wr_en), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - g_db, 0);
        chk("abort_writes", wq.size() - wbase, 20);
        run_one(rows[0]);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keyexp_sequencer.md
KEYEXP_SEQUENCER -- requirements
Module: keyexp_sequencer

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, meaning bit width of seeds, rates and map values.
REQ-002 SHALL provide parameter DEPTH, default 256, meaning entries per key vector (M and N); legal values are powers of two and at least 2.
REQ-003 SHALL have the following ports (AW = log2(DEPTH)):
- clk  input  1  sole clock; all logic rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request one expansion run.
- seed_m  input  WIDTH  initial M value (m).
- seed_n  input  WIDTH  initial N value (n).
- r1  input  WIDTH  rate parameter 1.
- r2  input  WIDTH  rate parameter 2.
- map_req  output  1  request to the shared chaotic-map unit.
- map_x0  output  WIDTH  map input state.
- map_rfs  output  WIDTH  map rfs operand.
- map_rs  output  WIDTH  map rs operand.
- map_ack  input  1  map result valid for the current request.
- map_x_next  input  WIDTH  map result.
- wr_en  output  1  key-buffer write strobe.
- wr_sel  output  1  0 = M vector, 1 = N vector.
- wr_addr  output  AW  entry index.
- wr_data  output  WIDTH  entry value.
- busy  output  1  run in progress.
- done  output  1  one-cycle completion pulse.
- abort  input  1  cancel run; present only with KEYEXP_ABORT_EN.

Function
REQ-004 SHALL implement the FSM states IDLE, SEED_M, SEED_N, CALC_M, CALC_N and DONE.
REQ-005 IDLE: start=1 SHALL latch seed_m, seed_n, r1 and r2 into internal registers and move to SEED_M; the latched values SHALL be used for the whole run.
REQ-006 SEED_M SHALL assert wr_en with wr_sel=0, wr_addr=0 and wr_data=latched seed_m for one cycle, then move to SEED_N.
REQ-007 SEED_N SHALL assert wr_en with wr_sel=1, wr_addr=0 and wr_data=latched seed_n for one cycle, set idx=1, then move to CALC_M.
REQ-008 CALC_M SHALL hold map_req=1, map_x0=last M value, map_rfs=r1 and map_rs=r2 until map_ack=1.
REQ-009 On the map_ack cycle in CALC_M, the block SHALL:
- assert wr_en with wr_sel=0, wr_addr=idx and wr_data=map_x_next (combinational, same cycle);
- update last M value to map_x_next;
- move to CALC_N.
REQ-010 CALC_N SHALL hold map_req=1, map_x0=last N value, map_rfs=r2 and map_rs=r1 until map_ack=1.
REQ-011 On the map_ack cycle in CALC_N, the block SHALL assert wr_en with wr_sel=1, wr_addr=idx and wr_data=map_x_next, update last N value, then:
- if idx=DEPTH-1, move to DONE;
- otherwise increment idx and move to CALC_M.
REQ-012 DONE SHALL assert done=1 for exactly one cycle, then move to IDLE.
REQ-013 busy SHALL be 1 in every state except IDLE.
REQ-014 start SHALL be ignored while busy=1; the block does not queue requests.
REQ-015 map_ack SHALL be ignored when map_req=0.
REQ-016 Outside the states and conditions above, wr_en and map_req SHALL be 0; map_x0, map_rfs and map_rs are don't-care while map_req=0.
REQ-017 With zero-wait ack (map_ack=1 whenever map_req=1) and start sampled at cycle T, the block SHALL:
- write at T+1..T+2*DEPTH, i.e. 2*DEPTH writes on consecutive cycles;
- pulse done at T+2*DEPTH+1.
REQ-018 Each map wait cycle SHALL add exactly one cycle of latency and produce no write.
REQ-019 The block SHALL pass map_x_next through unmodified; it performs no arithmetic on map values.
REQ-020 The block SHALL accept start in the cycle immediately after the done pulse.

Reset
REQ-021 rst_n=0 SHALL, asynchronously:
- force state to IDLE;
- clear idx, the latched registers and the last-M/last-N registers to 0;
- drive map_req=0, wr_en=0, busy=0 and done=0, with the other outputs at 0.
REQ-022 Reset asserted mid-run SHALL discard the run without a done pulse; after release the block SHALL wait in IDLE for a new start.

Configuration
REQ-023 With KEYEXP_ABORT_EN defined, the abort port SHALL exist, and abort=1 in any busy state SHALL:
- move the FSM to IDLE on the next edge;
- suppress wr_en and any last-value update in that cycle, taking priority over map_ack;
- produce no done pulse.
REQ-024 Without KEYEXP_ABORT_EN, the abort port and its logic SHALL be absent, and runs SHALL end only via DONE or reset.

Verification
REQ-025 DEPTH=256, zero-wait ack, seed_m=5, seed_n=9, map returning x0+1 -> 512 writes, with:
- M[i]=5+i and N[i]=9+i;
- M[255]=260 and N[255]=264;
- done at T+513.
REQ-026 Operand routing check -> map_rfs=r1 and map_rs=r2 on every M request; map_rfs=r2 and map_rs=r1 on every N request.
REQ-027 map_ack delayed 3 cycles on every request, DEPTH=4 -> 8 writes; done at T+1+8+6*3 = T+27; map_req stays high through each wait.
REQ-028 start pulsed at cycles T+5 and T+100 of a run -> ignored; exactly one done; write count unchanged.
REQ-029 rst_n pulled low during CALC_N at idx=40 -> outputs zero immediately; no done; a new start after release restarts writing from addr 0.
REQ-030 KEYEXP_ABORT_EN defined; abort coincident with map_ack at idx=10 in CALC_M -> no write that cycle; IDLE next cycle; busy=0; no done.
